// File: rtl/mealy_seq_detector_prog_if.sv
// rtl/mealy_seq_detector_prog_if.sv - stream, config and match signals of the programmable sequence detector
interface mealy_seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic                       in_valid;
    logic                       in;
    logic                       cfg_load;
    logic [NUM_PAT*MAX_LEN-1:0] cfg_pat;
    logic [NUM_PAT*LW-1:0]      cfg_len;
    logic                       cfg_overlap;
    logic                       y;
    logic [NUM_PAT-1:0]         y_id;
    logic [CNT_W-1:0]           match_cnt;

    modport master (
        output in_valid, in, cfg_load, cfg_pat, cfg_len, cfg_overlap,
        input  y, y_id, match_cnt
    );

    modport slave (
        input  in_valid, in, cfg_load, cfg_pat, cfg_len, cfg_overlap,
        output y, y_id, match_cnt
    );
endinterface

// File: rtl/mealy_seq_detector_prog.sv
// rtl/mealy_seq_detector_prog.sv - run-time programmable Mealy serial detector with overlap control and saturating match counter
module mealy_seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic reset,
    mealy_seq_detector_prog_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-2:0]         hist_q, hist_d;
    logic [LW-1:0]              fill_q, fill_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_PAT*MAX_LEN-1:0] pat_q;
    logic [NUM_PAT*LW-1:0]      len_q;
    logic                       ovl_q;

    logic [MAX_LEN-1:0] window;
    logic [NUM_PAT-1:0] y_id;
    logic               y;

    // Newest bit sits at window[0], matching pattern bit 0 (the last transmitted bit).
    assign window = {hist_q, bus.in};

    function automatic logic ch_match(input logic [MAX_LEN-1:0] pat,
                                      input logic [LW-1:0]      len,
                                      input logic [LW-1:0]      fill,
                                      input logic [MAX_LEN-1:0] win);
        logic hit;
        hit = 1'b1;
        if (len < LW'(2) || len > LW'(MAX_LEN))
            hit = 1'b0;
        else if (fill < len - LW'(1))
            hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(len) && win[i] != pat[i])
                hit = 1'b0;
        return hit;
    endfunction

    always_comb begin
        y_id = '0;
        for (int k = 0; k < NUM_PAT; k++)
            y_id[k] = bus.in_valid &
                      ch_match(pat_q[k*MAX_LEN +: MAX_LEN], len_q[k*LW +: LW], fill_q, window);
        y = |y_id;
    end

    assign bus.y         = y;
    assign bus.y_id      = y_id;
    assign bus.match_cnt = cnt_q;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (bus.cfg_load) begin
            // The bit arriving with a config load is dropped and the count restarts.
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (bus.in_valid) begin
            hist_d = window[MAX_LEN-2:0];
            if (y && !ovl_q)
                fill_d = '0;
            else if (fill_q != LW'(MAX_LEN - 1))
                fill_d = fill_q + LW'(1);
            if (y && cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    // Zero lengths after reset leave every channel disabled until the first load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b1;
        end else if (bus.cfg_load) begin
            pat_q <= bus.cfg_pat;
            len_q <= bus.cfg_len;
            ovl_q <= bus.cfg_overlap;
        end
    end
endmodule

// File: tb/tb_mealy_seq_detector_prog.sv
// tb/tb_mealy_seq_detector_prog.sv - scoreboard bench for the programmable Mealy sequence detector
module tb_mealy_seq_detector_prog;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [2:0] exp_q[$];
    logic [2:0] exp_v;
    logic [2:0] got_v;

    mealy_seq_detector_prog_if #(.MAX_LEN(8), .NUM_PAT(2), .CNT_W(8)) ifa ();
    mealy_seq_detector_prog_if #(.MAX_LEN(8), .NUM_PAT(2), .CNT_W(2)) ifb ();

    mealy_seq_detector_prog #(.MAX_LEN(8), .NUM_PAT(2), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    mealy_seq_detector_prog #(.MAX_LEN(8), .NUM_PAT(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step_a(input logic v, input logic b);
        @(posedge clk);
        #1;
        ifa.in_valid = v;
        ifa.in       = b;
        #4;
    endtask

    task automatic step_b(input logic v, input logic b);
        @(posedge clk);
        #1;
        ifb.in_valid = v;
        ifb.in       = b;
        #4;
    endtask

    task automatic prog_a(input logic [7:0] p0, input logic [7:0] p1,
                          input logic [3:0] l0, input logic [3:0] l1, input logic ovl);
        @(posedge clk);
        #1;
        ifa.in_valid    = 1'b0;
        ifa.cfg_pat     = {p1, p0};
        ifa.cfg_len     = {l1, l0};
        ifa.cfg_overlap = ovl;
        ifa.cfg_load    = 1'b1;
        @(posedge clk);
        #1;
        ifa.cfg_load    = 1'b0;
        ifa.cfg_pat     = '0;
        ifa.cfg_len     = '0;
        ifa.cfg_overlap = ~ovl;
    endtask

    task automatic prog_b(input logic [7:0] p0, input logic [7:0] p1,
                          input logic [3:0] l0, input logic [3:0] l1, input logic ovl);
        @(posedge clk);
        #1;
        ifb.in_valid    = 1'b0;
        ifb.cfg_pat     = {p1, p0};
        ifb.cfg_len     = {l1, l0};
        ifb.cfg_overlap = ovl;
        ifb.cfg_load    = 1'b1;
        @(posedge clk);
        #1;
        ifb.cfg_load    = 1'b0;
    endtask

    task automatic test_reset();
        ifa.in_valid = 1'b1;
        ifa.in       = 1'b1;
        #1;
        checks++;
        if ({ifa.y, ifa.y_id, ifa.match_cnt} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got y=%b y_id=%b cnt=%0d want 0/00/0", ifa.y, ifa.y_id, ifa.match_cnt);
        end
        ifa.in_valid = 1'b0;
        ifa.in       = 1'b0;
    endtask

    task automatic test_stream(input string name, input logic ovl, input int gaps, input int exp_cnt);
        logic [7:0] s;
        logic [1:0] e[8];
        s = 8'b10010110;
        e = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, (ovl ? 2'd1 : 2'd0)};
        prog_a(8'b00010110, 8'b00010010, 4'd5, 4'd5, ovl);
        checks++;
        if (ifa.match_cnt !== 8'd0) begin
            failures++;
            $display("FAIL %s_cnt_after_load got %0d want 0", name, ifa.match_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({|e[i], e[i]});
            step_a(1'b1, s[7-i]);
            got_v = {ifa.y, ifa.y_id};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL %s_bit%0d got y/y_id=%b want %b", name, i + 1, got_v, exp_v);
            end
            for (int g = 0; g < gaps && i < 7; g++) begin
                exp_q.push_back(3'b000);
                step_a(1'b0, 1'b1);
                got_v = {ifa.y, ifa.y_id};
                exp_v = exp_q.pop_front();
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s_gap%0d_%0d got y/y_id=%b want %b", name, i + 1, g, got_v, exp_v);
                end
            end
        end
        step_a(1'b0, 1'b0);
        checks++;
        if (ifa.match_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL %s_cnt got %0d want %0d", name, ifa.match_cnt, exp_cnt);
        end
    endtask

    task automatic test_multi_channel();
        logic [4:0] s;
        logic [1:0] e[5];
        s = 5'b10101;
        e = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd3};
        prog_a(8'b101, 8'b101, 4'd3, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({|e[i], e[i]});
            step_a(1'b1, s[4-i]);
            got_v = {ifa.y, ifa.y_id};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL multi_bit%0d got y/y_id=%b want %b", i + 1, got_v, exp_v);
            end
        end
        step_a(1'b0, 1'b0);
        checks++;
        if (ifa.match_cnt !== 8'd2) begin
            failures++;
            $display("FAIL multi_cnt got %0d want 2", ifa.match_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] e[6];
        e = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        prog_b(8'b11, 8'hFF, 4'd2, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({|e[i], e[i]});
            step_b(1'b1, 1'b1);
            got_v = {ifb.y, ifb.y_id};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL sat_bit%0d got y/y_id=%b want %b", i + 1, got_v, exp_v);
            end
            if (i == 2) begin
                checks++;
                if (ifb.match_cnt !== 2'd1) begin
                    failures++;
                    $display("FAIL sat_cnt_mid got %0d want 1", ifb.match_cnt);
                end
            end
        end
        step_b(1'b0, 1'b0);
        checks++;
        if (ifb.match_cnt !== 2'd3) begin
            failures++;
            $display("FAIL sat_cnt got %0d want 3", ifb.match_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] s;
        s = 5'b10101;
        prog_a(8'b101, 8'b101, 4'd3, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++)
            step_a(1'b1, s[4-i]);
        step_a(1'b1, 1'b1);
        checks++;
        if (ifa.y !== 1'b1 || ifa.match_cnt !== 8'd1) begin
            failures++;
            $display("FAIL prereset got y=%b cnt=%0d want 1/1", ifa.y, ifa.match_cnt);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({ifa.y, ifa.y_id, ifa.match_cnt} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset got y=%b y_id=%b cnt=%0d want 0/00/0", ifa.y, ifa.y_id, ifa.match_cnt);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(3'b000);
            step_a(1'b1, s[4-i]);
            got_v = {ifa.y, ifa.y_id};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL postreset_bit%0d got y/y_id=%b want %b", i + 1, got_v, exp_v);
            end
        end
    endtask

    task automatic test_len_bounds();
        logic [7:0] s;
        // ch0 at full length 8 (valid), ch1 at length 9 (disabled), then ch0 at length 0.
        s = 8'hA5;
        prog_a(8'hA5, 8'hA5, 4'd8, 4'd9, 1'b1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back((i == 7) ? 3'b101 : 3'b000);
            step_a(1'b1, s[7-i]);
            got_v = {ifa.y, ifa.y_id};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL len8_bit%0d got y/y_id=%b want %b", i + 1, got_v, exp_v);
            end
        end
        prog_a(8'hFF, 8'hFF, 4'd0, 4'd9, 1'b1);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(3'b000);
            step_a(1'b1, 1'b1);
            got_v = {ifa.y, ifa.y_id};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL lenbad_bit%0d got y/y_id=%b want %b", i + 1, got_v, exp_v);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        ifa.in_valid = 1'b0; ifa.in = 1'b0; ifa.cfg_load = 1'b0;
        ifa.cfg_pat = '0; ifa.cfg_len = '0; ifa.cfg_overlap = 1'b1;
        ifb.in_valid = 1'b0; ifb.in = 1'b0; ifb.cfg_load = 1'b0;
        ifb.cfg_pat = '0; ifb.cfg_len = '0; ifb.cfg_overlap = 1'b1;
        #12;
        test_reset();
        #10;
        reset = 1'b1;
        test_stream("ovl", 1'b1, 0, 2);
        test_stream("novl", 1'b0, 0, 1);
        test_multi_channel();
        test_stream("gaps", 1'b1, 3, 2);
        test_saturate();
        test_async_reset();
        test_len_bounds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
